// File: rtl/seg_scan_capture_pkg.sv
// Shared constants and helpers for the seven-segment scan capture block.
// Segment codes are active-low with bit 7 as the decimal point.
package seg_scan_capture_pkg;

   localparam logic [7:0] SEG_0     = 8'hC0;
   localparam logic [7:0] SEG_1     = 8'hF9;
   localparam logic [7:0] SEG_2     = 8'hA4;
   localparam logic [7:0] SEG_3     = 8'hB0;
   localparam logic [7:0] SEG_4     = 8'h99;
   localparam logic [7:0] SEG_5     = 8'h92;
   localparam logic [7:0] SEG_6     = 8'h82;
   localparam logic [7:0] SEG_7     = 8'hF8;
   localparam logic [7:0] SEG_8     = 8'h80;
   localparam logic [7:0] SEG_9     = 8'h90;
   localparam logic [7:0] SEG_BLANK = 8'hFF;

   localparam logic [3:0] BCD_INVALID  = 4'hF;
   localparam logic [3:0] ENABLE_BLANK = 4'b1111;

   // One-cold enable codes; the array index is the digit number they select.
   localparam logic [3:0] LEGAL_ENABLE [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

   typedef enum logic [1:0] {
      EN_BLANK,
      EN_LEGAL,
      EN_ILLEGAL
   } en_class_t;

   // Anything that is neither all-high nor exactly one low bit is a bus fault.
   function automatic en_class_t classify_enable(input logic [3:0] en);
      en_class_t cls;
      cls = EN_ILLEGAL;
      if (en == ENABLE_BLANK) cls = EN_BLANK;
      for (int i = 0; i < 4; i++) begin
         if (en == LEGAL_ENABLE[i]) cls = EN_LEGAL;
      end
      return cls;
   endfunction

   // Digit number selected by a legal enable; meaningless for other codes.
   function automatic logic [1:0] enable_index(input logic [3:0] en);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (en == LEGAL_ENABLE[i]) idx = 2'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/seg_scan_capture_if.sv
// Bundle of the multiplexed display bus and the rebuilt per-digit results.
// master: the side that drives the scan bus and consumes results.
// slave : the capture block.
interface seg_scan_capture_if;

   logic [7:0] seg;
   logic [3:0] enable;
   logic [7:0] digit0;
   logic [7:0] digit1;
   logic [7:0] digit2;
   logic [7:0] digit3;
   logic [3:0] bcd0;
   logic [3:0] bcd1;
   logic [3:0] bcd2;
   logic [3:0] bcd3;
   logic       frame_valid;
   logic       stale;
   logic       bus_err;
   logic [7:0] err_cnt;

   modport master (
      output seg, enable,
      input  digit0, digit1, digit2, digit3,
      input  bcd0, bcd1, bcd2, bcd3,
      input  frame_valid, stale, bus_err, err_cnt
   );

   modport slave (
      input  seg, enable,
      output digit0, digit1, digit2, digit3,
      output bcd0, bcd1, bcd2, bcd3,
      output frame_valid, stale, bus_err, err_cnt
   );

endinterface

// File: rtl/seg_scan_capture_seg7_to_bcd.sv
// Combinational seven-segment to BCD decoder. The decimal point is ignored;
// unrecognised patterns decode to 4'hF.
module seg7_to_bcd
   import seg_scan_capture_pkg::*;
(
   input  logic [7:0] seg,
   output logic [3:0] bcd
);

   logic [7:0] seg_nodp;

   assign seg_nodp = {1'b1, seg[6:0]};

   // Table lookup on the pattern with dp forced off.
   always_comb begin
      bcd = BCD_INVALID;
      case (seg_nodp)
         SEG_0:   bcd = 4'd0;
         SEG_1:   bcd = 4'd1;
         SEG_2:   bcd = 4'd2;
         SEG_3:   bcd = 4'd3;
         SEG_4:   bcd = 4'd4;
         SEG_5:   bcd = 4'd5;
         SEG_6:   bcd = 4'd6;
         SEG_7:   bcd = 4'd7;
         SEG_8:   bcd = 4'd8;
         SEG_9:   bcd = 4'd9;
         default: bcd = BCD_INVALID;
      endcase
   end

endmodule

// File: rtl/seg_scan_capture.sv
// Receive side of a 4-digit multiplexed seven-segment bus. Rebuilds the four
// segment bytes once each digit's enable has been stable for SETTLE samples,
// decodes them to BCD, pulses frame_valid when all four are fresh, and tracks
// illegal enable patterns and bus inactivity.
module seg_scan_capture
   import seg_scan_capture_pkg::*;
#(
   parameter int          SETTLE  = 4,
   parameter int          TO_W    = 20,
   parameter int unsigned TIMEOUT = 2**20 - 1
) (
   input logic               clk,
   input logic               rst,
   seg_scan_capture_if.slave bus
);

   localparam int SET_W = $clog2(SETTLE + 1);
   localparam logic [SET_W-1:0] SETTLE_V  = SET_W'(SETTLE);
   localparam logic [TO_W-1:0]  TIMEOUT_V = TO_W'(TIMEOUT);

   logic [7:0]       seg_p0;
   logic [7:0]       seg_p1;
   logic [3:0]       en_p0;
   logic [3:0]       en_p1;
   logic [3:0]       en_prev;

   logic [SET_W-1:0] settle;
   logic [SET_W-1:0] settle_next;
   logic [3:0]       mask;
   logic [TO_W-1:0]  to_cnt;
   logic [TO_W-1:0]  to_next;
   logic             frame_valid;
   logic             stale;
   logic             bus_err;
   logic [7:0]       err_cnt;

   logic [7:0]       digit [4];
   logic [3:0]       bcd   [4];

   en_class_t        en_cls;
   logic             en_changed;
   logic             capture;
   logic [1:0]       cap_idx;
   logic [3:0]       cap_bits;
   logic [3:0]       bcd_dec;

   // Stage p0/p1: two-flop input register on the segment bus.
   always_ff @(posedge clk) begin
      seg_p0 <= bus.seg;
      seg_p1 <= seg_p0;
   end

   // Stage p0/p1: two-flop input register on the enables; reset to blank so
   // the classifier never sees an undefined code out of reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         en_p0 <= ENABLE_BLANK;
         en_p1 <= ENABLE_BLANK;
      end else begin
         en_p0 <= bus.enable;
         en_p1 <= en_p0;
      end
   end

   seg7_to_bcd u_decode (
      .seg (seg_p1),
      .bcd (bcd_dec)
   );

   assign en_cls     = classify_enable(en_p1);
   assign en_changed = (en_p1 != en_prev);
   assign cap_idx    = enable_index(en_p1);

   // Settle counter next state and the single-shot capture strobe. A capture
   // fires only on the transition into SETTLE, so a held enable never
   // re-captures even if the segment lines move.
   always_comb begin
      settle_next = settle;
      if (en_cls != EN_LEGAL) begin
         settle_next = '0;
      end else if (en_changed) begin
         settle_next = SET_W'(1);
      end else if (settle < SETTLE_V) begin
         settle_next = settle + 1'b1;
      end
      capture  = (en_cls == EN_LEGAL) && (settle_next == SETTLE_V) &&
                 (en_changed || (settle != SETTLE_V));
      cap_bits = capture ? (4'b0001 << cap_idx) : 4'b0000;
   end

   // Idle counter saturates at TIMEOUT and is cleared by any capture.
   always_comb begin
      to_next = to_cnt;
      if (capture) begin
         to_next = '0;
      end else if (to_cnt != TIMEOUT_V) begin
         to_next = to_cnt + 1'b1;
      end
   end

   // Control state: settle tracking, frame mask/handshake, timeout and errors.
   always_ff @(posedge clk) begin
      if (rst) begin
         en_prev     <= ENABLE_BLANK;
         settle      <= '0;
         mask        <= 4'b0000;
         frame_valid <= 1'b0;
         to_cnt      <= '0;
         stale       <= 1'b0;
         bus_err     <= 1'b0;
         err_cnt     <= 8'd0;
      end else begin
         en_prev <= en_p1;
         settle  <= settle_next;
         // A full mask is reported one cycle later and restarts collection;
         // a capture landing in that cycle seeds the new frame.
         if (mask == 4'b1111) begin
            frame_valid <= 1'b1;
            mask        <= cap_bits;
         end else begin
            frame_valid <= 1'b0;
            mask        <= mask | cap_bits;
         end
         to_cnt <= to_next;
         stale  <= (to_next == TIMEOUT_V);
         if (en_cls == EN_ILLEGAL) begin
            bus_err <= 1'b1;
            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
         end
      end
   end

   // Per-digit capture registers; blank and invalid until first captured.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            digit[i] <= SEG_BLANK;
            bcd[i]   <= BCD_INVALID;
         end
      end else if (capture) begin
         digit[cap_idx] <= seg_p1;
         bcd[cap_idx]   <= bcd_dec;
      end
   end

   assign bus.digit0      = digit[0];
   assign bus.digit1      = digit[1];
   assign bus.digit2      = digit[2];
   assign bus.digit3      = digit[3];
   assign bus.bcd0        = bcd[0];
   assign bus.bcd1        = bcd[1];
   assign bus.bcd2        = bcd[2];
   assign bus.bcd3        = bcd[3];
   assign bus.frame_valid = frame_valid;
   assign bus.stale       = stale;
   assign bus.bus_err     = bus_err;
   assign bus.err_cnt     = err_cnt;

endmodule

// File: tb/tb_seg_scan_capture.sv
// Directed bench for seg_scan_capture. Expected frames are queued when a full
// scan is issued; a negedge monitor pops one per frame_valid pulse.
module tb_seg_scan_capture;

   logic clk;
   logic rst;

   seg_scan_capture_if bus ();

   seg_scan_capture #(
      .SETTLE  (4),
      .TO_W    (20),
      .TIMEOUT (16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct packed {
      logic [3:0][7:0] d;
      logic [3:0][3:0] b;
   } frame_t;

   frame_t exp_q[$];
   int     checks     = 0;
   int     failures   = 0;
   int     frames_seen = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Hold enable/seg for n cycles; returns 1 time unit after the last edge.
   task automatic drive(input logic [3:0] en, input logic [7:0] sg, input int n);
      bus.enable = en;
      bus.seg    = sg;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_frame(input logic [7:0] d3, d2, d1, d0,
                             input logic [3:0] b3, b2, b1, b0);
      frame_t f;
      f.d = {d3, d2, d1, d0};
      f.b = {b3, b2, b1, b0};
      exp_q.push_back(f);
   endtask

   // Scoreboard monitor: every frame_valid cycle must match a queued frame.
   always @(negedge clk) begin
      if (!rst && bus.frame_valid) begin
         frame_t e;
         frames_seen++;
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL frame_unexpected actual=1 required=0 digits=%h_%h_%h_%h",
                     bus.digit3, bus.digit2, bus.digit1, bus.digit0);
         end else begin
            e = exp_q.pop_front();
            if ({bus.digit3, bus.digit2, bus.digit1, bus.digit0} !== e.d) begin
               failures++;
               $display("FAIL frame_digits actual=%h required=%h",
                        {bus.digit3, bus.digit2, bus.digit1, bus.digit0}, e.d);
            end
            checks++;
            if ({bus.bcd3, bus.bcd2, bus.bcd1, bus.bcd0} !== e.b) begin
               failures++;
               $display("FAIL frame_bcd actual=%h required=%h",
                        {bus.bcd3, bus.bcd2, bus.bcd1, bus.bcd0}, e.b);
            end
         end
      end
   end

   initial begin
      rst        = 1'b1;
      bus.seg    = 8'hFF;
      bus.enable = 4'hF;
      repeat (3) @(posedge clk);
      #1;
      check("rst_digit0",      bus.digit0, 8'hFF);
      check("rst_bcd3",        bus.bcd3, 4'hF);
      check("rst_frame_valid", bus.frame_valid, 1'b0);
      check("rst_stale",       bus.stale, 1'b0);
      check("rst_bus_err",     bus.bus_err, 1'b0);
      check("rst_err_cnt",     bus.err_cnt, 8'd0);
      rst = 1'b0;

      // Basic scan of 0..3
      push_frame(8'hB0, 8'hA4, 8'hF9, 8'hC0, 4'd3, 4'd2, 4'd1, 4'd0);
      drive(4'b1110, 8'hC0, 10);
      drive(4'b1101, 8'hF9, 10);
      drive(4'b1011, 8'hA4, 10);
      drive(4'b0111, 8'hB0, 10);
      drive(4'hF, 8'hFF, 4);
      check("scan_frames", frames_seen, 1);
      check("scan_bcd", {bus.bcd3, bus.bcd2, bus.bcd1, bus.bcd0}, 16'h3210);

      // Enable held one cycle short of SETTLE: no capture
      rst = 1'b1;
      drive(4'hF, 8'hFF, 2);
      rst = 1'b0;
      drive(4'b1110, 8'h80, 3);
      drive(4'hF, 8'hFF, 6);
      check("short_digit0", bus.digit0, 8'hFF);
      check("short_bcd0",   bus.bcd0, 4'hF);
      check("short_frames", frames_seen, 1);

      // Illegal enables: sticky flag, counting and saturation
      drive(4'b1100, 8'hFF, 3);
      drive(4'hF, 8'hFF, 4);
      check("illegal_bus_err", bus.bus_err, 1'b1);
      check("illegal_err_cnt", bus.err_cnt, 8'd3);
      check("illegal_digit0",  bus.digit0, 8'hFF);
      drive(4'b1100, 8'hFF, 300);
      drive(4'hF, 8'hFF, 4);
      check("sat_err_cnt", bus.err_cnt, 8'd255);
      check("sat_bus_err", bus.bus_err, 1'b1);

      // dp handling in decode
      drive(4'b1011, 8'h7F, 10);
      check("dp_only_digit2", bus.digit2, 8'h7F);
      check("dp_only_bcd2",   bus.bcd2, 4'hF);
      drive(4'hF, 8'hFF, 2);
      drive(4'b1011, 8'h40, 10);
      check("zero_dp_digit2", bus.digit2, 8'h40);
      check("zero_dp_bcd2",   bus.bcd2, 4'd0);

      // Stale timeout: last capture 4 cycles before this point
      drive(4'hF, 8'hFF, 11);
      check("stale_at_15", bus.stale, 1'b0);
      drive(4'hF, 8'hFF, 1);
      check("stale_at_16", bus.stale, 1'b1);
      drive(4'hF, 8'hFF, 8);
      check("stale_held", bus.stale, 1'b1);
      drive(4'b1110, 8'hC0, 5);
      check("stale_before_cap", bus.stale, 1'b1);
      drive(4'b1110, 8'hC0, 1);
      check("stale_cleared", bus.stale, 1'b0);
      check("stale_cap_digit0", bus.digit0, 8'hC0);
      drive(4'b1110, 8'hC0, 4);

      // Reset mid-frame discards the partial mask
      rst = 1'b1;
      drive(4'hF, 8'hFF, 2);
      rst = 1'b0;
      check("rst2_bus_err", bus.bus_err, 1'b0);
      check("rst2_err_cnt", bus.err_cnt, 8'd0);
      check("rst2_digit2",  bus.digit2, 8'hFF);
      drive(4'b1110, 8'h99, 10);
      drive(4'b1101, 8'h80, 10);
      check("pre_rst_digit1", bus.digit1, 8'h80);
      rst = 1'b1;
      drive(4'hF, 8'hFF, 2);
      rst = 1'b0;
      check("mid_rst_digit0", bus.digit0, 8'hFF);
      check("mid_rst_digit1", bus.digit1, 8'hFF);
      push_frame(8'h82, 8'h92, 8'h90, 8'hF8, 4'd6, 4'd5, 4'd9, 4'd7);
      drive(4'b1011, 8'h92, 10);
      drive(4'b0111, 8'h82, 10);
      check("no_early_frame", frames_seen, 1);
      drive(4'b1110, 8'hF8, 10);
      drive(4'b1101, 8'h90, 10);
      drive(4'hF, 8'hFF, 4);
      check("post_rst_frames", frames_seen, 2);
      check("queue_drained", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
